// File: rtl/cvxif_copro_scheduler.sv
// cvxif_copro_scheduler: in-order issue scheduler for one CV-X-IF custom
// coprocessor FU. Accepted offloads are queued, wait for commit or kill, are
// dispatched to the FU one at a time and write back in program order.
// Optional build macro CVXIF_SCHED_PERF_EN adds issue/kill performance counters.

package cvxif_copro_pkg;
  typedef enum logic [2:0] {
    OP_NOP = 3'd0,
    MV_V_X = 3'd1,
    MV_X_V = 3'd2,
    VADD   = 3'd3,
    VSUB   = 3'd4,
    VMUL   = 3'd5
  } custom_vec_op_e;
endpackage

// Warns when an issue arrives carrying an id that is still outstanding.
module cvxif_copro_scheduler_chk #(
  parameter int Depth   = 4,
  parameter int IdWidth = 3
) (
  input logic               clk_i,
  input logic               rst_i,
  input logic               issue_fire_i,
  input logic [IdWidth-1:0] issue_id_i,
  input logic [Depth-1:0]   vld_i,
  input logic [IdWidth-1:0] ids_i [Depth]
);
  logic dup_s;

  // Any occupied slot already holding the incoming id.
  always_comb begin
    dup_s = 1'b0;
    for (int i = 0; i < Depth; i++) begin
      if (vld_i[i] && (ids_i[i] == issue_id_i)) begin
        dup_s = 1'b1;
      end else begin
        dup_s = dup_s;
      end
    end
  end

  a_unique_id: assert property (@(posedge clk_i) disable iff (rst_i) issue_fire_i |-> !dup_s)
    else $warning("cvxif_copro_scheduler: issue id %0d already outstanding", issue_id_i);
endmodule

module cvxif_copro_scheduler
  import cvxif_copro_pkg::*;
#(
  parameter int Depth     = 4,
  parameter int IdWidth   = 3,
  parameter int DataWidth = 64
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 issue_valid_i,
  output logic                 issue_ready_o,
  input  logic [IdWidth-1:0]   issue_id_i,
  input  logic [DataWidth-1:0] issue_rs0_i,
  input  logic [DataWidth-1:0] issue_rs1_i,
  input  logic                 dec_accept_i,
  input  logic                 dec_writeback_i,
  input  custom_vec_op_e       dec_op_i,
  output logic                 issue_accept_o,
  output logic                 issue_writeback_o,
  input  logic                 commit_valid_i,
  input  logic [IdWidth-1:0]   commit_id_i,
  input  logic                 commit_kill_i,
  output logic                 exec_valid_o,
  input  logic                 exec_ready_i,
  output custom_vec_op_e       exec_op_o,
  output logic [DataWidth-1:0] exec_rs0_o,
  output logic [DataWidth-1:0] exec_rs1_o,
  input  logic                 fu_done_i,
  input  logic [DataWidth-1:0] fu_data_i,
  output logic                 result_valid_o,
  input  logic                 result_ready_i,
  output logic [IdWidth-1:0]   result_id_o,
  output logic [DataWidth-1:0] result_data_o
`ifdef CVXIF_SCHED_PERF_EN
  ,
  output logic [31:0]          perf_issued_o,
  output logic [31:0]          perf_killed_o
`endif
);
  localparam int PtrW = $clog2(Depth);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_EXEC   = 2'd1,
    S_WAIT   = 2'd2,
    S_RESULT = 2'd3
  } state_e;

  state_e               state_r, state_next_s;
  logic [PtrW-1:0]      head_r, tail_r;
  logic [PtrW:0]        count_r;
  logic [Depth-1:0]     vld_r, cmt_r, kill_r, wb_r;
  logic [IdWidth-1:0]   id_r  [Depth];
  custom_vec_op_e       op_r  [Depth];
  logic [DataWidth-1:0] rs0_r [Depth];
  logic [DataWidth-1:0] rs1_r [Depth];
  logic [DataWidth-1:0] res_data_r;
  logic                 issue_fire_s, enq_s, enq_cmt_s, head_ready_s;
  logic                 pop_s, kill_pop_s, capture_s;

  assign issue_ready_o     = (count_r != (PtrW+1)'(Depth));
  assign issue_fire_s      = issue_valid_i & issue_ready_o;
  assign enq_s             = issue_fire_s & dec_accept_i;
  assign enq_cmt_s         = commit_valid_i & (commit_id_i == issue_id_i);
  assign issue_accept_o    = issue_fire_s & dec_accept_i;
  assign issue_writeback_o = issue_fire_s & dec_accept_i & dec_writeback_i;
  assign head_ready_s      = vld_r[head_r] & cmt_r[head_r];

  // FSM state register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_r <= S_IDLE;
    else       state_r <= state_next_s;
  end

  // FSM next-state: killed heads are dropped in IDLE, committed ones dispatched.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      S_IDLE: begin
        if (head_ready_s && !kill_r[head_r]) state_next_s = S_EXEC;
        else                                 state_next_s = S_IDLE;
      end
      S_EXEC: begin
        if (exec_ready_i) state_next_s = S_WAIT;
        else              state_next_s = S_EXEC;
      end
      S_WAIT: begin
        if (fu_done_i) state_next_s = wb_r[head_r] ? S_RESULT : S_IDLE;
        else           state_next_s = S_WAIT;
      end
      S_RESULT: begin
        if (result_ready_i) state_next_s = S_IDLE;
        else                state_next_s = S_RESULT;
      end
      default: state_next_s = S_IDLE;
    endcase
  end

  // FSM outputs: FU/result handshakes and queue pop strobes; zero when inactive.
  always_comb begin
    pop_s          = 1'b0;
    kill_pop_s     = 1'b0;
    capture_s      = 1'b0;
    exec_valid_o   = 1'b0;
    exec_op_o      = OP_NOP;
    exec_rs0_o     = {DataWidth{1'b0}};
    exec_rs1_o     = {DataWidth{1'b0}};
    result_valid_o = 1'b0;
    result_id_o    = {IdWidth{1'b0}};
    result_data_o  = {DataWidth{1'b0}};
    case (state_r)
      S_IDLE: begin
        if (head_ready_s && kill_r[head_r]) begin
          pop_s      = 1'b1;
          kill_pop_s = 1'b1;
        end else begin
          pop_s      = 1'b0;
        end
      end
      S_EXEC: begin
        exec_valid_o = 1'b1;
        exec_op_o    = op_r[head_r];
        exec_rs0_o   = rs0_r[head_r];
        exec_rs1_o   = rs1_r[head_r];
      end
      S_WAIT: begin
        if (fu_done_i) begin
          capture_s = 1'b1;
          pop_s     = !wb_r[head_r];
        end else begin
          capture_s = 1'b0;
        end
      end
      S_RESULT: begin
        result_valid_o = 1'b1;
        result_id_o    = id_r[head_r];
        result_data_o  = res_data_r;
        pop_s          = result_ready_i;
      end
      default: pop_s = 1'b0;
    endcase
  end

  // Queue control: pointers, occupancy, commit/kill flags and result capture.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      head_r     <= {PtrW{1'b0}};
      tail_r     <= {PtrW{1'b0}};
      count_r    <= {(PtrW+1){1'b0}};
      vld_r      <= {Depth{1'b0}};
      cmt_r      <= {Depth{1'b0}};
      kill_r     <= {Depth{1'b0}};
      wb_r       <= {Depth{1'b0}};
      res_data_r <= {DataWidth{1'b0}};
    end else begin
      // Already-committed entries ignore further commit/kill (covers a late kill of an active head).
      for (int i = 0; i < Depth; i++) begin
        if (commit_valid_i && vld_r[i] && !cmt_r[i] && (id_r[i] == commit_id_i)) begin
          cmt_r[i]  <= 1'b1;
          kill_r[i] <= commit_kill_i;
        end
      end
      if (enq_s) begin
        vld_r[tail_r]  <= 1'b1;
        wb_r[tail_r]   <= dec_writeback_i;
        cmt_r[tail_r]  <= enq_cmt_s;
        kill_r[tail_r] <= enq_cmt_s & commit_kill_i;
        tail_r         <= tail_r + PtrW'(1);
      end
      if (pop_s) begin
        vld_r[head_r]  <= 1'b0;
        cmt_r[head_r]  <= 1'b0;
        kill_r[head_r] <= 1'b0;
        head_r         <= head_r + PtrW'(1);
      end
      count_r <= count_r + (PtrW+1)'(enq_s) - (PtrW+1)'(pop_s);
      if (capture_s) res_data_r <= fu_data_i;
      else           res_data_r <= res_data_r;
    end
  end

  // Queue payload; only meaningful while the matching valid bit is set.
  always_ff @(posedge clk_i) begin
    if (enq_s) begin
      id_r[tail_r]  <= issue_id_i;
      op_r[tail_r]  <= dec_op_i;
      rs0_r[tail_r] <= issue_rs0_i;
      rs1_r[tail_r] <= issue_rs1_i;
    end
  end

`ifdef CVXIF_SCHED_PERF_EN
  logic [31:0] perf_issued_r, perf_killed_r;

  // Free-running counters of accepted issues and killed entries dropped.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      perf_issued_r <= 32'd0;
      perf_killed_r <= 32'd0;
    end else begin
      perf_issued_r <= perf_issued_r + (enq_s ? 32'd1 : 32'd0);
      perf_killed_r <= perf_killed_r + (kill_pop_s ? 32'd1 : 32'd0);
    end
  end

  assign perf_issued_o = perf_issued_r;
  assign perf_killed_o = perf_killed_r;
`else
  // Performance counters not built in this configuration.
`endif

  cvxif_copro_scheduler_chk #(.Depth(Depth), .IdWidth(IdWidth)) u_chk (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .issue_fire_i (issue_fire_s),
    .issue_id_i   (issue_id_i),
    .vld_i        (vld_r),
    .ids_i        (id_r)
  );
endmodule

// File: tb/tb_cvxif_copro_scheduler.sv
// Directed testbench for cvxif_copro_scheduler with hand-computed expectations.
module tb_cvxif_copro_scheduler;
  import cvxif_copro_pkg::*;

  logic           clk_i = 1'b0;
  logic           rst_i;
  logic           issue_valid_i, issue_ready_o;
  logic [2:0]     issue_id_i;
  logic [63:0]    issue_rs0_i, issue_rs1_i;
  logic           dec_accept_i, dec_writeback_i;
  custom_vec_op_e dec_op_i;
  logic           issue_accept_o, issue_writeback_o;
  logic           commit_valid_i, commit_kill_i;
  logic [2:0]     commit_id_i;
  logic           exec_valid_o, exec_ready_i;
  custom_vec_op_e exec_op_o;
  logic [63:0]    exec_rs0_o, exec_rs1_o;
  logic           fu_done_i;
  logic [63:0]    fu_data_i;
  logic           result_valid_o, result_ready_i;
  logic [2:0]     result_id_o;
  logic [63:0]    result_data_o;
`ifdef CVXIF_SCHED_PERF_EN
  logic [31:0]    perf_issued_o, perf_killed_o;
`endif

  int n_err = 0;
  int n_chk = 0;

  cvxif_copro_scheduler dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .issue_valid_i(issue_valid_i), .issue_ready_o(issue_ready_o),
    .issue_id_i(issue_id_i), .issue_rs0_i(issue_rs0_i), .issue_rs1_i(issue_rs1_i),
    .dec_accept_i(dec_accept_i), .dec_writeback_i(dec_writeback_i), .dec_op_i(dec_op_i),
    .issue_accept_o(issue_accept_o), .issue_writeback_o(issue_writeback_o),
    .commit_valid_i(commit_valid_i), .commit_id_i(commit_id_i), .commit_kill_i(commit_kill_i),
    .exec_valid_o(exec_valid_o), .exec_ready_i(exec_ready_i), .exec_op_o(exec_op_o),
    .exec_rs0_o(exec_rs0_o), .exec_rs1_o(exec_rs1_o),
    .fu_done_i(fu_done_i), .fu_data_i(fu_data_i),
    .result_valid_o(result_valid_o), .result_ready_i(result_ready_i),
    .result_id_o(result_id_o), .result_data_o(result_data_o)
`ifdef CVXIF_SCHED_PERF_EN
    , .perf_issued_o(perf_issued_o), .perf_killed_o(perf_killed_o)
`endif
  );

  always #5 clk_i = ~clk_i;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle_in;
    issue_valid_i = 1'b0; issue_id_i = 3'd0; issue_rs0_i = 64'd0; issue_rs1_i = 64'd0;
    dec_accept_i = 1'b0; dec_writeback_i = 1'b0; dec_op_i = OP_NOP;
    commit_valid_i = 1'b0; commit_id_i = 3'd0; commit_kill_i = 1'b0;
    exec_ready_i = 1'b0; fu_done_i = 1'b0; fu_data_i = 64'd0; result_ready_i = 1'b0;
  endtask

  task automatic issue(input logic [2:0] id, input logic [63:0] rs0, input logic commit_now);
    issue_valid_i = 1'b1; issue_id_i = id; issue_rs0_i = rs0; issue_rs1_i = 64'd0;
    dec_accept_i = 1'b1; dec_writeback_i = 1'b1; dec_op_i = VADD;
    commit_valid_i = commit_now; commit_id_i = id; commit_kill_i = 1'b0;
  endtask

  initial begin
    int ex_n, res_n, found, bad;
    logic [63:0] ex_log [4];
    logic [63:0] res_log [4];
    logic [63:0] ex_rs0, res_id, res_data;
    logic chk_ready_next;

    // Reset state
    rst_i = 1'b1;
    idle_in();
    tick(); tick();
    check_eq("rst_issue_ready", 64'(issue_ready_o), 64'd1);
    check_eq("rst_exec_valid", 64'(exec_valid_o), 64'd0);
    check_eq("rst_exec_rs0", exec_rs0_o, 64'd0);
    check_eq("rst_result_valid", 64'(result_valid_o), 64'd0);
    check_eq("rst_result_id", 64'(result_id_o), 64'd0);
    check_eq("rst_result_data", result_data_o, 64'd0);
    check_eq("rst_issue_accept", 64'(issue_accept_o), 64'd0);
    rst_i = 1'b0;
    tick();

    // Test 1: issue+commit id=1 MV_V_X, exec at t+2, result after fu_done
    issue(3'd1, 64'h5, 1'b1);
    dec_op_i = MV_V_X;
    #1;
    check_eq("t1_accept", 64'(issue_accept_o), 64'd1);
    check_eq("t1_writeback", 64'(issue_writeback_o), 64'd1);
    tick(); idle_in();
    check_eq("t1_exec_t1", 64'(exec_valid_o), 64'd0);
    tick();
    check_eq("t1_exec_t2", 64'(exec_valid_o), 64'd1);
    check_eq("t1_exec_op", 64'(exec_op_o), 64'(MV_V_X));
    check_eq("t1_exec_rs0", exec_rs0_o, 64'h5);
    exec_ready_i = 1'b1;
    tick(); exec_ready_i = 1'b0;
    check_eq("t1_wait_exec", 64'(exec_valid_o), 64'd0);
    check_eq("t1_wait_result", 64'(result_valid_o), 64'd0);
    fu_done_i = 1'b1; fu_data_i = 64'h5;
    tick(); fu_done_i = 1'b0; fu_data_i = 64'd0;
    check_eq("t1_result_valid", 64'(result_valid_o), 64'd1);
    check_eq("t1_result_id", 64'(result_id_o), 64'd1);
    check_eq("t1_result_data", result_data_o, 64'h5);
    result_ready_i = 1'b1;
    tick(); result_ready_i = 1'b0;
    check_eq("t1_result_done", 64'(result_valid_o), 64'd0);

    // Test 2: rejected issue leaves queue empty
    issue_valid_i = 1'b1; issue_id_i = 3'd2; dec_accept_i = 1'b0; dec_writeback_i = 1'b1;
    #1;
    check_eq("t2_accept", 64'(issue_accept_o), 64'd0);
    check_eq("t2_writeback", 64'(issue_writeback_o), 64'd0);
    tick(); idle_in();
    commit_valid_i = 1'b1; commit_id_i = 3'd2;
    tick(); idle_in();
    tick(); tick();
    check_eq("t2_no_exec", 64'(exec_valid_o), 64'd0);

    // Test 3: fill, then commit all and drain in order
    for (int i = 0; i < 4; i++) begin
      check_eq($sformatf("t3_ready_fill%0d", i), 64'(issue_ready_o), 64'd1);
      issue(3'(i), 64'h10 + 64'(i), 1'b0);
      tick(); idle_in();
    end
    check_eq("t3_full", 64'(issue_ready_o), 64'd0);
    ex_n = 0; res_n = 0; chk_ready_next = 1'b0;
    for (int cyc = 0; cyc < 40; cyc++) begin
      commit_valid_i = (cyc < 4); commit_id_i = 3'(cyc);
      exec_ready_i = 1'b1; fu_done_i = 1'b1; fu_data_i = 64'h77; result_ready_i = 1'b1;
      #1;
      if (chk_ready_next) begin
        check_eq("t3_ready_after_pop", 64'(issue_ready_o), 64'd1);
        chk_ready_next = 1'b0;
      end
      if (exec_valid_o) begin
        if (ex_n < 4) ex_log[ex_n] = exec_rs0_o;
        ex_n++;
      end
      if (result_valid_o) begin
        check_eq("t3_res_data", result_data_o, 64'h77);
        if (res_n == 0) begin
          check_eq("t3_ready_before_pop", 64'(issue_ready_o), 64'd0);
          chk_ready_next = 1'b1;
        end
        if (res_n < 4) res_log[res_n] = 64'(result_id_o);
        res_n++;
      end
      tick();
    end
    idle_in();
    check_eq("t3_exec_count", 64'(ex_n), 64'd4);
    check_eq("t3_result_count", 64'(res_n), 64'd4);
    for (int k = 0; k < 4; k++) begin
      check_eq($sformatf("t3_exec_order%0d", k), ex_log[k], 64'h10 + 64'(k));
      check_eq($sformatf("t3_result_order%0d", k), res_log[k], 64'(k));
    end

    // Test 4: kill id 2, commit id 3 (fresh reset so counters start at 0)
    rst_i = 1'b1; tick(); tick(); rst_i = 1'b0; tick();
    issue(3'd2, 64'h22, 1'b0); tick();
    issue(3'd3, 64'h33, 1'b0); tick(); idle_in();
    commit_valid_i = 1'b1; commit_id_i = 3'd2; commit_kill_i = 1'b1; tick();
    commit_valid_i = 1'b1; commit_id_i = 3'd3; commit_kill_i = 1'b0; tick();
    idle_in();
    ex_n = 0; res_n = 0; ex_rs0 = 64'd0; res_id = 64'd0; res_data = 64'd0;
    for (int cyc = 0; cyc < 20; cyc++) begin
      exec_ready_i = 1'b1; fu_done_i = 1'b1; fu_data_i = 64'h44; result_ready_i = 1'b1;
      #1;
      if (exec_valid_o) begin ex_n++; ex_rs0 = exec_rs0_o; end
      if (result_valid_o) begin res_n++; res_id = 64'(result_id_o); res_data = result_data_o; end
      tick();
    end
    idle_in();
    check_eq("t4_exec_count", 64'(ex_n), 64'd1);
    check_eq("t4_exec_rs0", ex_rs0, 64'h33);
    check_eq("t4_result_count", 64'(res_n), 64'd1);
    check_eq("t4_result_id", res_id, 64'd3);
    check_eq("t4_result_data", res_data, 64'h44);
`ifdef CVXIF_SCHED_PERF_EN
    check_eq("t4_perf_killed", 64'(perf_killed_o), 64'd1);
    check_eq("t4_perf_issued", 64'(perf_issued_o), 64'd2);
`endif

    // Test 5: result back-pressure holds id/data and blocks the next dispatch
    issue(3'd5, 64'h55, 1'b1); tick();
    issue(3'd6, 64'h66, 1'b1); tick(); idle_in();
    exec_ready_i = 1'b1; fu_done_i = 1'b1; fu_data_i = 64'hBEEF;
    found = 0;
    for (int k = 0; k < 10; k++) begin
      if (result_valid_o) begin found = 1; break; end
      tick();
    end
    check_eq("t5_result_seen", 64'(found), 64'd1);
    fu_data_i = 64'h1234;
    for (int h = 0; h < 5; h++) begin
      check_eq($sformatf("t5_hold_valid%0d", h), 64'(result_valid_o), 64'd1);
      check_eq($sformatf("t5_hold_id%0d", h), 64'(result_id_o), 64'd5);
      check_eq($sformatf("t5_hold_data%0d", h), result_data_o, 64'hBEEF);
      check_eq($sformatf("t5_hold_noexec%0d", h), 64'(exec_valid_o), 64'd0);
      tick();
    end
    result_ready_i = 1'b1;
    found = 0; ex_rs0 = 64'd0; res_id = 64'd0; res_data = 64'd0;
    tick();
    for (int k = 0; k < 10; k++) begin
      if (exec_valid_o && ex_rs0 == 64'd0) ex_rs0 = exec_rs0_o;
      if (result_valid_o) begin
        found = 1; res_id = 64'(result_id_o); res_data = result_data_o;
        break;
      end
      tick();
    end
    tick(); idle_in();
    check_eq("t5_next_exec_rs0", ex_rs0, 64'h66);
    check_eq("t5_next_result_seen", 64'(found), 64'd1);
    check_eq("t5_next_result_id", res_id, 64'd6);
    check_eq("t5_next_result_data", res_data, 64'h1234);

    // Test 6: reset while waiting on the FU; a late fu_done gives no result
    issue(3'd7, 64'h77, 1'b1); tick(); idle_in();
    exec_ready_i = 1'b1;
    found = 0;
    for (int k = 0; k < 6; k++) begin
      if (exec_valid_o) begin found = 1; break; end
      tick();
    end
    check_eq("t6_exec_seen", 64'(found), 64'd1);
    tick(); exec_ready_i = 1'b0;
    rst_i = 1'b1;
    #1;
    check_eq("t6_rst_exec_valid", 64'(exec_valid_o), 64'd0);
    check_eq("t6_rst_result_valid", 64'(result_valid_o), 64'd0);
    check_eq("t6_rst_result_data", result_data_o, 64'd0);
    check_eq("t6_rst_issue_ready", 64'(issue_ready_o), 64'd1);
    tick(); rst_i = 1'b0;
    fu_done_i = 1'b1; fu_data_i = 64'h99;
    tick(); idle_in();
    bad = 0;
    for (int k = 0; k < 5; k++) begin
      if (result_valid_o || exec_valid_o) bad++;
      tick();
    end
    check_eq("t6_no_late_result", 64'(bad), 64'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
